// File: rtl/serial_eq_pkg.sv
// -----------------------------------------------------------------------------
// serial_eq_pkg
// Shared definitions for the serial equality comparator:
//   state_t    - comparator FSM states (IDLE, RUN, DONE)
//   WIDTH_DEF  - default number of bit pairs per comparison
//   cnt_w()    - bit counter width for a given WIDTH; one spare bit so the
//                counter can reach WIDTH without wrapping
// -----------------------------------------------------------------------------
package serial_eq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_DEF = 8;

   function automatic int cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_eq_bitcnt.sv
// -----------------------------------------------------------------------------
// serial_eq_bitcnt
// Counts accepted bit pairs within one comparison.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, counter to 0
//   clr  - synchronous clear (new comparison accepted)
//   en   - count one accepted bit pair
//   last - high while the counter points at bit WIDTH-1
// -----------------------------------------------------------------------------
module serial_eq_bitcnt
   import serial_eq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         // The extra MSB lets the final increment land on WIDTH instead of
         // wrapping to 0; the FSM has left RUN by then.
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/serial_eq_cmp.sv
// -----------------------------------------------------------------------------
// serial_eq_cmp
// Compares two LSB-first serial operands of WIDTH bits for equality.
// Parameter:
//   WIDTH   - bit pairs per comparison (2..32)
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   start   - request a new comparison (honoured in IDLE and DONE only)
//   bit_vld - a/b carry a valid bit pair this cycle
//   a, b    - serial operand bits, LSB first
//   busy    - comparison in progress (state RUN)
//   done    - one-cycle pulse when a comparison completes
//   eq      - registered result, stable from done until the next comparison
//   mis_cnt - number of mismatching bit pairs in the last comparison
//             (present only when SERIAL_EQ_MISMATCH_CNT_EN is defined)
// Optional feature macro: SERIAL_EQ_MISMATCH_CNT_EN
// -----------------------------------------------------------------------------
module serial_eq_cmp
   import serial_eq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic bit_vld,
   input  logic a,
   input  logic b,
   output logic busy,
   output logic done,
   output logic eq
`ifdef SERIAL_EQ_MISMATCH_CNT_EN
   ,
   output logic [cnt_w(WIDTH)-1:0] mis_cnt
`endif
);

   state_t state;
   state_t state_nxt;

   logic   acc;
   logic   bit_eq;
   logic   accept;
   logic   step;
   logic   last;
   logic   final_step;

   assign bit_eq     = ~(a ^ b);
   // start is only honoured when no comparison is running.
   assign accept     = start && (state != RUN);
   assign step       = (state == RUN) && bit_vld;
   assign final_step = step && last;

   serial_eq_bitcnt #(
      .WIDTH (WIDTH)
   ) u_bitcnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (step),
      .last (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            if (final_step) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= 1'b1;
         eq  <= 1'b0;
      end else if (accept) begin
         acc <= 1'b1;
      end else if (step) begin
         acc <= acc & bit_eq;
         // The last bit is folded in here directly since acc itself only
         // updates on this same edge.
         if (last) eq <= acc & bit_eq;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

`ifdef SERIAL_EQ_MISMATCH_CNT_EN
   localparam int CNT_W = cnt_w(WIDTH);

   logic [CNT_W-1:0] mis_run;
   logic [CNT_W-1:0] mis_inc;

   assign mis_inc = {{(CNT_W-1){1'b0}}, ~bit_eq};

   always_ff @(posedge clk) begin
      if (rst) begin
         mis_run <= '0;
         mis_cnt <= '0;
      end else if (accept) begin
         mis_run <= '0;
         mis_cnt <= '0;
      end else if (step) begin
         mis_run <= mis_run + mis_inc;
         if (last) mis_cnt <= mis_run + mis_inc;
      end
   end
`endif

endmodule

// File: tb/tb_serial_eq_cmp.sv
// -----------------------------------------------------------------------------
// tb_serial_eq_cmp
// Directed self-checking bench for serial_eq_cmp with WIDTH=8.
// Optional feature macro: SERIAL_EQ_MISMATCH_CNT_EN (mis_cnt checks)
// -----------------------------------------------------------------------------
module tb_serial_eq_cmp;

   localparam int WIDTH = 8;

   logic clk;
   logic rst;
   logic start;
   logic bit_vld;
   logic a;
   logic b;
   logic busy;
   logic done;
   logic eq;
`ifdef SERIAL_EQ_MISMATCH_CNT_EN
   logic [3:0] mis_cnt;
`endif

   int n_cmp;
   int n_bad;

   serial_eq_cmp #(
      .WIDTH (WIDTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bit_vld (bit_vld),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .eq      (eq)
`ifdef SERIAL_EQ_MISMATCH_CNT_EN
      ,
      .mis_cnt (mis_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_cmp();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Feeds WIDTH bit pairs, optionally stalling nstall cycles before bit
   // stall_pos, and optionally holding start high during RUN. Returns with
   // the edge that samples the last bit just taken.
   task automatic feed(input logic [7:0] av, input logic [7:0] bv,
                       input int stall_pos, input int nstall, input bit hold_start,
                       output int early_done, output bit busy_all, output bit eq_moved);
      logic eq0;
      eq0        = eq;
      early_done = 0;
      busy_all   = 1'b1;
      eq_moved   = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i == stall_pos) begin
            for (int s = 0; s < nstall; s++) begin
               start   = hold_start;
               bit_vld = 1'b0;
               a       = ~av[i];
               b       = bv[i];
               tick();
               if (done) early_done++;
               if (!busy) busy_all = 1'b0;
               if (eq !== eq0) eq_moved = 1'b1;
            end
         end
         start   = hold_start && (i < WIDTH - 1);
         bit_vld = 1'b1;
         a       = av[i];
         b       = bv[i];
         tick();
         if (i < WIDTH - 1) begin
            if (done) early_done++;
            if (!busy) busy_all = 1'b0;
            if (eq !== eq0) eq_moved = 1'b1;
         end
      end
      start   = 1'b0;
      bit_vld = 1'b0;
      a       = 1'b0;
      b       = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; bit_vld = 1'b1; a = 1'b1; b = 1'b0;
      tick();
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (eq !== 1'b0) begin n_bad++; $display("FAIL reset_eq: got %b want 0", eq); end
`ifdef SERIAL_EQ_MISMATCH_CNT_EN
      n_cmp++; if (mis_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_mis: got %0d want 0", mis_cnt); end
`endif
      rst = 1'b0; start = 1'b0; bit_vld = 1'b0; a = 1'b0; b = 1'b0;
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_equal();
      int ed; bit ba; bit em;
      start_cmp();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL eqop_busy_start: got %b want 1", busy); end
      feed(8'hA5, 8'hA5, -1, 0, 1'b0, ed, ba, em);
      n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL eqop_early_done: got %0d want 0", ed); end
      n_cmp++; if (ba !== 1'b1) begin n_bad++; $display("FAIL eqop_busy_run: got %b want 1", ba); end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL eqop_done_cycle9: got %b want 1", done); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL eqop_busy_done: got %b want 0", busy); end
      n_cmp++; if (eq !== 1'b1) begin n_bad++; $display("FAIL eqop_eq: got %b want 1", eq); end
`ifdef SERIAL_EQ_MISMATCH_CNT_EN
      n_cmp++; if (mis_cnt !== 4'd0) begin n_bad++; $display("FAIL eqop_mis: got %0d want 0", mis_cnt); end
`endif
      tick();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL eqop_done_pulse: got %b want 0", done); end
      n_cmp++; if (eq !== 1'b1) begin n_bad++; $display("FAIL eqop_eq_hold: got %b want 1", eq); end
   endtask

   task automatic test_unequal();
      int ed; bit ba; bit em;
      start_cmp();
      feed(8'hA5, 8'hA4, -1, 0, 1'b0, ed, ba, em);
      n_cmp++; if (em !== 1'b0) begin n_bad++; $display("FAIL neq1_eq_stable_run: got %b want 0", em); end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL neq1_done: got %b want 1", done); end
      n_cmp++; if (eq !== 1'b0) begin n_bad++; $display("FAIL neq1_eq: got %b want 0", eq); end
`ifdef SERIAL_EQ_MISMATCH_CNT_EN
      n_cmp++; if (mis_cnt !== 4'd1) begin n_bad++; $display("FAIL neq1_mis: got %0d want 1", mis_cnt); end
`endif
      tick();
      start_cmp();
      feed(8'hFF, 8'h00, -1, 0, 1'b0, ed, ba, em);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL neq8_done: got %b want 1", done); end
      n_cmp++; if (eq !== 1'b0) begin n_bad++; $display("FAIL neq8_eq: got %b want 0", eq); end
`ifdef SERIAL_EQ_MISMATCH_CNT_EN
      n_cmp++; if (mis_cnt !== 4'd8) begin n_bad++; $display("FAIL neq8_mis: got %0d want 8", mis_cnt); end
`endif
      tick();
   endtask

   task automatic test_stall();
      int ed; bit ba; bit em;
      int pos;
      pos = int'($urandom_range(1, 6));
      start_cmp();
      feed(8'h3C, 8'h3C, pos, 3, 1'b0, ed, ba, em);
      n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL stall_early_done: got %0d want 0", ed); end
      n_cmp++; if (ba !== 1'b1) begin n_bad++; $display("FAIL stall_busy_run: got %b want 1", ba); end
      n_cmp++; if (em !== 1'b0) begin n_bad++; $display("FAIL stall_eq_stable_run: got %b want 0", em); end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done_cycle12: got %b want 1", done); end
      n_cmp++; if (eq !== 1'b1) begin n_bad++; $display("FAIL stall_eq: got %b want 1", eq); end
      tick();
   endtask

   task automatic test_back_to_back();
      int ed; bit ba; bit em;
      start_cmp();
      feed(8'h5A, 8'h5B, -1, 0, 1'b1, ed, ba, em);
      n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL hold_start_early_done: got %0d want 0", ed); end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL hold_start_done: got %b want 1", done); end
      n_cmp++; if (eq !== 1'b0) begin n_bad++; $display("FAIL hold_start_eq: got %b want 0", eq); end
`ifdef SERIAL_EQ_MISMATCH_CNT_EN
      n_cmp++; if (mis_cnt !== 4'd1) begin n_bad++; $display("FAIL hold_start_mis: got %0d want 1", mis_cnt); end
`endif
      // start during the DONE cycle
      start_cmp();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_low: got %b want 0", done); end
      feed(8'hC3, 8'hC3, -1, 0, 1'b0, ed, ba, em);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b want 1", done); end
      n_cmp++; if (eq !== 1'b1) begin n_bad++; $display("FAIL b2b_eq: got %b want 1", eq); end
`ifdef SERIAL_EQ_MISMATCH_CNT_EN
      n_cmp++; if (mis_cnt !== 4'd0) begin n_bad++; $display("FAIL b2b_mis: got %0d want 0", mis_cnt); end
`endif
      tick();
   endtask

   task automatic test_abort();
      int ed; bit ba; bit em;
      int seen;
      logic [7:0] v;
      v = 8'h96;
      start_cmp();
      for (int i = 0; i < 4; i++) begin
         bit_vld = 1'b1; a = v[i]; b = v[i];
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; bit_vld = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", done); end
      n_cmp++; if (eq !== 1'b0) begin n_bad++; $display("FAIL abort_eq: got %b want 0", eq); end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         bit_vld = 1'b1; a = 1'b0; b = 1'b0;
         tick();
         if (done || busy) seen++;
      end
      bit_vld = 1'b0;
      n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
      start_cmp();
      feed(8'h00, 8'h00, -1, 0, 1'b0, ed, ba, em);
      n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL fresh_early_done: got %0d want 0", ed); end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL fresh_done: got %b want 1", done); end
      n_cmp++; if (eq !== 1'b1) begin n_bad++; $display("FAIL fresh_eq: got %b want 1", eq); end
      tick();
   endtask

   task automatic test_idle_ignore();
      int ed; bit ba; bit em;
      int act;
      int eqchg;
      act = 0; eqchg = 0;
      for (int i = 0; i < 10; i++) begin
         bit_vld = 1'b1; a = 1'b1; b = 1'b0;
         tick();
         if (busy || done) act++;
         if (eq !== 1'b1) eqchg++;
      end
      bit_vld = 1'b0; a = 1'b0;
      n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL idle_active: got %0d want 0", act); end
      n_cmp++; if (eqchg !== 0) begin n_bad++; $display("FAIL idle_eq_hold: got %0d changed cycles want 0", eqchg); end
      start_cmp();
      feed(8'hA5, 8'hA5, -1, 0, 1'b0, ed, ba, em);
      n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL idle_next_early_done: got %0d want 0", ed); end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL idle_next_done: got %b want 1", done); end
      n_cmp++; if (eq !== 1'b1) begin n_bad++; $display("FAIL idle_next_eq: got %b want 1", eq); end
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1; start = 1'b0; bit_vld = 1'b0; a = 1'b0; b = 1'b0;
      test_reset();
      test_equal();
      test_unequal();
      test_stall();
      test_back_to_back();
      test_abort();
      test_idle_ignore();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
